// File: rtl/inst_fetch_seq.sv
// inst_fetch_seq: fetches instruction words from program memory, issues them on the IR bus
// and waits for execute completion; stops on HALT opcode or memory timeout.
module inst_fetch_seq #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                TIMEOUT  = 15,
    parameter logic [4:0]        HALT_OP  = 5'b11111
) (
    input  logic              clk,
    input  logic              sys_rst,
    input  logic              start,
    output logic              imem_rd_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              imem_rvalid,
    output logic [31:0]       ir_out,
    output logic              ir_valid,
    input  logic              exec_done,
    output logic [ADDR_W-1:0] pc_out,
    output logic              halted,
    output logic              fetch_err,
    output logic              busy
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT, ISSUE, EXEC, HALTED} state_t;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);
    state_t state, state_n;
    logic [ADDR_W-1:0] pc, pc_n, addr_n, pc_out_n;
    logic [7:0] cnt, cnt_n;
    logic [31:0] ir_n;
    logic rd_en_n, ir_valid_n, halted_n, err_n, busy_n;
    always_comb begin
        state_n    = state;
        pc_n       = pc;
        addr_n     = imem_addr;
        pc_out_n   = pc_out;
        cnt_n      = cnt;
        ir_n       = ir_out;
        rd_en_n    = 1'b0;
        ir_valid_n = 1'b0;
        halted_n   = halted;
        err_n      = fetch_err;
        case (state)
            IDLE, HALTED: if (start) begin
                pc_n     = RESET_PC;
                addr_n   = RESET_PC;
                halted_n = 1'b0;
                err_n    = 1'b0;
                rd_en_n  = 1'b1;
                state_n  = REQ;
            end
            REQ: begin
                cnt_n   = '0;
                state_n = WAIT;
            end
            // ir_valid is registered, so it is decided here and lands in the ISSUE cycle
            WAIT: if (imem_rvalid) begin
                ir_n       = imem_rdata;
                pc_out_n   = pc;
                ir_valid_n = imem_rdata[31:27] != HALT_OP;
                state_n    = ISSUE;
            end else begin
                cnt_n = cnt + 8'd1;
                if (cnt == CNT_LAST) begin
                    err_n    = 1'b1;
                    halted_n = 1'b1;
                    state_n  = HALTED;
                end
            end
            ISSUE: begin
                halted_n = ir_out[31:27] == HALT_OP;
                state_n  = ir_out[31:27] == HALT_OP ? HALTED : EXEC;
            end
            EXEC: if (exec_done) begin
                pc_n    = pc + ADDR_W'(1);
                addr_n  = pc + ADDR_W'(1);
                rd_en_n = 1'b1;
                state_n = REQ;
            end
            default: state_n = IDLE;
        endcase
        busy_n = state_n != IDLE && state_n != HALTED;
    end
    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            imem_addr  <= '0;
            pc_out     <= '0;
            cnt        <= '0;
            ir_out     <= '0;
            imem_rd_en <= 1'b0;
            ir_valid   <= 1'b0;
            halted     <= 1'b0;
            fetch_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            imem_addr  <= addr_n;
            pc_out     <= pc_out_n;
            cnt        <= cnt_n;
            ir_out     <= ir_n;
            imem_rd_en <= rd_en_n;
            ir_valid   <= ir_valid_n;
            halted     <= halted_n;
            fetch_err  <= err_n;
            busy       <= busy_n;
        end
    end
endmodule
